// File: rtl/majority_vote_controller_if.sv
// Voting bus between the voter pool / consumer and the
// majority vote controller.
interface majority_vote_controller_if;
  logic       start;
  logic [4:0] vote_valid;
  logic [4:0] vote_val;
  logic [4:0] vote_ack;
  logic [4:0] present;
  logic       busy;
  logic       result_valid;
  logic       result;
  logic       timed_out;
  logic       result_ready;

  modport master (
    output start,
    output vote_valid,
    output vote_val,
    output result_ready,
    input  vote_ack,
    input  present,
    input  busy,
    input  result_valid,
    input  result,
    input  timed_out
  );

  modport slave (
    input  start,
    input  vote_valid,
    input  vote_val,
    input  result_ready,
    output vote_ack,
    output present,
    output busy,
    output result_valid,
    output result,
    output timed_out
  );
endinterface

// File: rtl/majority_vote_controller.sv
// Five-voter ballot collector with timeout and a
// registered majority decision held until consumed.
module majority_vote_controller #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  majority_vote_controller_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EVAL    = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CMAX =
    {CNT_W{1'b1}};
  localparam logic [4:0] ALL = 5'b11111;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       present_q;
  logic [4:0]       ballot_q;
  logic             result_q;
  logic             to_q;
  logic             rv_q;
  logic [4:0]       acc;
  logic [2:0]       yes_cnt;
  logic             full;
  logic             expire;

  always_comb begin
    acc = '0;
    if (state == COLLECT)
      acc = bus.vote_valid & ~present_q;
  end

  assign full   = (present_q | acc) == ALL;
  assign expire = cnt == LAST;

  // Absent voters have ballot masked off, so
  // they count as "no".
  always_comb begin
    yes_cnt = '0;
    for (int i = 0; i < 5; i++)
      yes_cnt = yes_cnt
              + 3'(ballot_q[i] & present_q[i]);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.start) state_nx = COLLECT;
      COLLECT:
        if (full || expire) state_nx = EVAL;
      EVAL:
        state_nx = HOLD;
      HOLD:
        if (rv_q && bus.result_ready)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      present_q <= '0;
      ballot_q  <= '0;
      result_q  <= 1'b0;
      to_q      <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt       <= '0;
            present_q <= '0;
            ballot_q  <= '0;
          end
        end
        COLLECT: begin
          ballot_q  <= (ballot_q & ~acc)
                     | (bus.vote_val & acc);
          present_q <= present_q | acc;
          if (cnt != CMAX) cnt <= cnt + 1'b1;
        end
        EVAL: begin
          result_q <= yes_cnt >= 3'd3;
          to_q     <= present_q != ALL;
        end
        HOLD: begin
          // valid rises one cycle into HOLD, after
          // the decision registers have settled
          if (!rv_q)
            rv_q <= 1'b1;
          else if (bus.result_ready)
            rv_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.vote_ack     = acc;
  assign bus.present      = present_q;
  assign bus.busy         = state != IDLE;
  assign bus.result_valid = rv_q;
  assign bus.result       = result_q;
  assign bus.timed_out    = to_q;

endmodule
